// File: rtl/alu_seq_exec_if.sv
// Handshake bundle for the EX-stage execute unit: request side (op + operands)
// and response side (result + zero flag), each with its own valid/ready pair.
interface alu_seq_exec_if #(
    parameter int WIDTH = 32
);
    // A transfer happens on a rising edge where valid && ready; the sender holds
    // its payload stable until then, and valid never waits on ready.
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALU_ctr;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, ALU_ctr, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, ALU_ctr, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute unit: single-cycle logic/arith ops, iterative 1-bit/cycle
// shifts, registered result and zero flag behind valid/ready handshakes.
module alu_seq_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_seq_exec_if.slave      bus,
    output logic [1:0]         fsm_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     acc;
    logic [SHAMT_W-1:0]   cnt;
    logic                 shift_left;
    logic [WIDTH-1:0]     imm_res;
    logic [WIDTH-1:0]     acc_step;
    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    logic                 accept;
    logic                 last_step;

    assign shamt     = bus.src_b[SHAMT_W-1:0];
    assign is_shift  = (bus.ALU_ctr == 4'd5) || (bus.ALU_ctr == 4'd6);
    // Held low during reset so upstream never sees a ready it cannot use.
    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = (state == DONE);
    assign accept    = bus.in_valid && bus.in_ready;
    assign last_step = (cnt == SHAMT_W'(1));
    assign acc_step  = shift_left ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
    assign fsm_state = state;

    // Single-cycle result; shifts by zero fall through as a copy of src_a.
    always_comb begin
        imm_res = '0;
        case (bus.ALU_ctr)
            4'd0:    imm_res = bus.src_a + bus.src_b;
            4'd1:    imm_res = bus.src_a - bus.src_b;
            4'd2:    imm_res = bus.src_a & bus.src_b;
            4'd3:    imm_res = bus.src_a | bus.src_b;
            4'd4:    imm_res = bus.src_a ^ bus.src_b;
            4'd5,
            4'd6:    imm_res = bus.src_a;
            4'd7:    imm_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            default: imm_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) state_nxt = SHIFT;
                    else                           state_nxt = DONE;
                end
            end
            SHIFT: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            bus.result <= '0;
            bus.zero   <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                if (is_shift && (shamt != '0)) begin
                    acc        <= bus.src_a;
                    cnt        <= shamt;
                    shift_left <= (bus.ALU_ctr == 4'd5);
                end else begin
                    bus.result <= imm_res;
                    bus.zero   <= (imm_res == '0);
                end
            end else if (state == SHIFT) begin
                acc <= acc_step;
                cnt <= cnt - 1'b1;
                if (last_step) begin
                    bus.result <= acc_step;
                    bus.zero   <= (acc_step == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized plus directed bench for alu_seq_exec against a barrel-shift /
// plain-arithmetic reference model with an expected-result queue.
module tb_alu_seq_exec;
    localparam int W = 32;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm_state;

    alu_seq_exec_if #(.WIDTH(W)) bus ();

    alu_seq_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] ctr, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (ctr)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] ctr, input logic [W-1:0] b);
        if ((ctr == 4'd5 || ctr == 4'd6) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("ready_timeout", 0, 1);
    endtask

    // Issue one op, check latency/result/zero, optionally stall the consumer.
    task automatic run_op(input logic [3:0] ctr, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit pulse);
        logic [W-1:0] exp_r;
        int exp_lat;
        int lat;
        exp_q.push_back(ref_alu(ctr, a, b));
        exp_lat = ref_lat(ctr, b);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.ALU_ctr  = ctr;
        bus.src_a    = a;
        bus.src_b    = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.ALU_ctr  = 4'($urandom);
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
        check("latency", lat, exp_lat);
        exp_r = exp_q.pop_front();
        check("result", bus.result, exp_r);
        check("zero", {31'd0, bus.zero}, {31'd0, exp_r == 0});
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = pulse && (i == 3);
            if (pulse) begin
                bus.ALU_ctr = 4'd0;
                bus.src_a   = $urandom;
                bus.src_b   = $urandom;
            end
            @(negedge clk);
            check("stall_result", bus.result, exp_r);
            check("stall_valid", {31'd0, bus.out_valid}, 1);
            if (pulse) check("stall_in_ready", {31'd0, bus.in_ready}, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("valid_drop", {31'd0, bus.out_valid}, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.ALU_ctr   = 4'd0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", {31'd0, bus.zero}, 0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 1);

        // out_ready while nothing is pending must be harmless
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_out_ready", {31'd0, bus.out_valid}, 0);
        bus.out_ready = 1'b0;

        run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 0, 0);
        run_op(4'd1, 32'd5, 32'd5, 0, 0);
        run_op(4'd7, 32'hFFFF_FFFF, 32'h1, 0, 0);
        run_op(4'd7, 32'h1, 32'hFFFF_FFFF, 0, 0);
        run_op(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0);
        run_op(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0);
        run_op(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0);
        run_op(4'd5, 32'h1, 32'h23, 0, 0);
        run_op(4'd6, 32'h8000_0000, 32'd31, 0, 0);
        run_op(4'd5, 32'hDEAD_BEEF, 32'h40, 0, 0);
        run_op(4'd12, 32'h1234, 32'h0, 0, 0);
        run_op(4'd0, 32'hFFFF_FFFF, 32'h1, 10, 1);
        run_op(4'd1, 32'd9, 32'd3, 0, 0);

        // Reset in the middle of a long shift abandons it.
        wait_ready();
        bus.in_valid = 1'b1;
        bus.ALU_ctr  = 4'd6;
        bus.src_a    = 32'h8000_0000;
        bus.src_b    = 32'd20;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 0);
        repeat (3) begin
            @(negedge clk);
            check("held_rst_out_valid", {31'd0, bus.out_valid}, 0);
            check("held_rst_in_ready", {31'd0, bus.in_ready}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'd0, bus.in_ready}, 1);
        check("rel_out_valid", {31'd0, bus.out_valid}, 0);
        run_op(4'd0, 32'd2, 32'd3, 0, 0);

        for (int k = 0; k < 200; k++) begin
            logic [3:0]   c;
            logic [W-1:0] a;
            logic [W-1:0] b;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(c, a, b, $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
